// File: rtl/ff_mul_serial.sv
// Bit-serial MSB-first interleaved modular multiplier over GF(2^255 - 19).
// Define FF_MUL_RADIX4_EN to process two multiplier bits per RUN iteration.
module ff_mul_serial #(
  parameter logic [254:0] P = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a_i,
  input  logic [254:0] b_i,
  output logic [254:0] out,
  output logic         done,
  output logic         busy
);

`ifdef FF_MUL_RADIX4_EN
  localparam int CNT_W = 7;
  localparam int B_W   = 256;
  localparam logic [CNT_W-1:0] CNT_TOP = 7'd127;
`else
  localparam int CNT_W = 8;
  localparam int B_W   = 255;
  localparam logic [CNT_W-1:0] CNT_TOP = 8'd254;
`endif

  localparam logic [255:0] P_EXT = {1'b0, P};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_reg, state_next;
  logic [254:0]       a_reg;
  logic [B_W-1:0]     b_reg;
  logic [254:0]       acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [254:0]       out_reg;
  logic               done_reg;
  logic               busy_reg;

  logic               accept_en;
  logic               load_en;
  logic               run_en;
  logic               last_en;
  logic [254:0]       a_red;
  logic [254:0]       acc_step;

  // One double / conditional-add step; acc < p and a < p keep every sum below 2^256.
  function automatic logic [254:0] dbl_add(input logic [254:0] acc,
                                           input logic [254:0] a,
                                           input logic         b_bit);
    logic [255:0] t;
    logic [255:0] u;
    t = {acc, 1'b0};
    if (t >= P_EXT) t = t - P_EXT;
    u = t + (b_bit ? {1'b0, a} : 256'd0);
    if (u >= P_EXT) u = u - P_EXT;
    return u[254:0];
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept_en = 1'b0;
    load_en   = 1'b0;
    run_en    = 1'b0;
    last_en   = 1'b0;
    case (state_reg)
      IDLE:    accept_en = start;
      LOAD:    load_en   = 1'b1;
      RUN: begin
        run_en  = 1'b1;
        last_en = (cnt_reg == '0);
      end
      default: ;
    endcase
  end

  // a_i < 2^255 < 2p, so a single conditional subtraction canonicalises it.
  assign a_red = ({1'b0, a_reg} >= P_EXT) ? (a_reg - P) : a_reg;

`ifdef FF_MUL_RADIX4_EN
  assign acc_step = dbl_add(dbl_add(acc_reg, a_reg, b_reg[{cnt_reg, 1'b1}]),
                            a_reg, b_reg[{cnt_reg, 1'b0}]);
`else
  assign acc_step = dbl_add(acc_reg, a_reg, b_reg[cnt_reg]);
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept_en) begin
        a_reg    <= a_i;
        b_reg    <= B_W'(b_i);
        busy_reg <= 1'b1;
      end
      if (load_en) begin
        a_reg   <= a_red;
        acc_reg <= '0;
        cnt_reg <= CNT_TOP;
      end
      if (run_en) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (last_en) begin
        out_reg  <= acc_step;
        done_reg <= 1'b1;
        busy_reg <= 1'b0;
      end
    end
  end

  assign out  = out_reg;
  assign done = done_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_ff_mul_serial.sv
// Scoreboard bench for ff_mul_serial: directed vectors plus a short back-to-back run.
module tb_ff_mul_serial;

  localparam logic [254:0] P = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
`ifdef FF_MUL_RADIX4_EN
  localparam int LAT = 129;
`else
  localparam int LAT = 256;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [254:0] a_i, b_i;
  logic [254:0] out;
  logic         done, busy;

  int           tests = 0;
  int           fails = 0;
  logic [254:0] exp_q[$];
  logic         prev_done = 1'b0;

  ff_mul_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_i   (a_i),
    .b_i   (b_i),
    .out   (out),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [254:0] golden(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] prod;
    prod = {257'd0, a} * {257'd0, b};
    prod = prod % {257'd0, P};
    return prod[254:0];
  endfunction

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    logic [254:0] e;
    if (rst) begin
      prev_done <= 1'b0;
    end else begin
      if (done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_done actual=%h required=no done", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            fails++;
            $display("FAIL result actual=%h required=%h", out, e);
          end else begin
            $display("[TB] result out=%h", out);
          end
        end
        if (prev_done) begin
          tests++;
          fails++;
          $display("FAIL done_width actual=2+ cycles required=1 cycle");
        end
      end
      prev_done <= done;
    end
  end

  // One operation; optionally pulses a second start 50 cycles in, which must be ignored.
  task automatic run_op(input logic [254:0] a, input logic [254:0] b,
                        input logic [254:0] e, input bit inject);
    int cyc;
    int busyc;
    @(negedge clk);
    a_i = a; b_i = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (busy) busyc++;
      if (inject && cyc == 50) begin
        a_i = 255'd7; b_i = 255'd9; start = 1'b1;
      end
      if (inject && cyc == 51) start = 1'b0;
      if (done) break;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout actual=no done required=done within 1000 cycles");
    end
    check("latency", 255'(cyc - 1), 255'(LAT));
    check("busy_cycles", 255'(busyc), 255'(LAT));
  endtask

  initial begin
    int cyc;
    logic [254:0] ra, rb;
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, '0);
    check("reset_done", 255'(done), '0);
    check("reset_busy", 255'(busy), '0);
    @(negedge clk) rst = 1'b0;

    run_op('0, 255'h1234, '0, 1'b0);
    run_op(P - 255'd1, P - 255'd1, 255'd1, 1'b0);
    run_op(255'd1 << 254, 255'd2, 255'd19, 1'b0);
    run_op(P, 255'd5, '0, 1'b0);
    run_op(P + 255'd3, 255'd2, 255'd6, 1'b0);
    run_op({255{1'b1}}, 255'd1, 255'd18, 1'b0);
    run_op(255'd3, {255{1'b1}}, 255'd54, 1'b0);
    run_op(P - 255'd1, 255'd2, P - 255'd2, 1'b0);
    run_op(255'd1 << 128, 255'd1 << 127, 255'd19, 1'b0);

    // Second start mid-operation must be dropped.
    run_op(255'd11, 255'd13, 255'd143, 1'b1);
    repeat (20) @(negedge clk);
    check("ignored_start_busy", 255'(busy), '0);

    // Reset during RUN abandons the operation.
    @(negedge clk);
    a_i = 255'd100; b_i = 255'd200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (101) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_out", out, '0);
    check("midrun_rst_done", 255'(done), '0);
    check("midrun_rst_busy", 255'(busy), '0);
    @(negedge clk) rst = 1'b0;
    run_op(255'd5, 255'd7, 255'd35, 1'b0);

    // Back-to-back with start held high through each done cycle.
    @(negedge clk);
    ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a_i = ra; b_i = rb; start = 1'b1;
    exp_q.push_back(golden(ra, rb));
    @(posedge clk);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a_i = ra; b_i = rb;
      exp_q.push_back(golden(ra, rb));
      cyc = 0;
      while (!done && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      if (!done) begin
        tests++; fails++;
        $display("FAIL b2b_timeout actual=no done required=done");
      end
      @(posedge clk);
    end
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (10) @(negedge clk);
    check("queue_drained", 255'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
